key_conditioner: RTL and testbench

Parametrised N-channel push-button front end for the board top level. It replaces per-key bare synchronisers with a block that does four things per channel: multi-stage synchronisation, polarity normalisation, counter-based debounce, and press/release edge detection. Sticky edge-capture bits with masked clear and a level interrupt let a soft-core PIO read discrete key events instead of polling levels. It sits between the raw KEY pins and the system interconnect, in the clk domain produced by the PLL.

---
 rtl/key_conditioner_if.sv | 27 ++
 rtl/key_conditioner.sv | 86 ++++++++
 tb/tb_key_conditioner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw key pins in, debounced levels, edge strobes,
// sticky capture flags and interrupt out, plus capture-clear and irq enables.
//   master : drives key_in, clr_wr, clr_mask, irq_en; observes the rest
//   slave  : the conditioner itself
interface key_conditioner_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] key_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] edge_capture;
  logic                clr_wr;
  logic [CHANNELS-1:0] clr_mask;
  logic [CHANNELS-1:0] irq_en;
  logic                irq;

  modport master (
    output key_in, clr_wr, clr_mask, irq_en,
    input  level_out, press_pulse, release_pulse, edge_capture, irq
  );

  modport slave (
    input  key_in, clr_wr, clr_mask, irq_en,
    output level_out, press_pulse, release_pulse, edge_capture, irq
  );
endinterface

// File: rtl/key_conditioner.sv
// N-channel push-button front end: synchroniser, polarity normalisation,
// counter debounce, press/release strobes, sticky press capture with masked
// clear, and a level interrupt.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : key_conditioner_if.slave (key_in, clr_wr, clr_mask, irq_en in;
//          level_out, press_pulse, release_pulse, edge_capture, irq out)
module key_conditioner #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  key_conditioner_if.slave      bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CHANNELS-1:0] IDLE = {CHANNELS{ACTIVE_LOW}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] cap_q, cap_d;
  logic [CHANNELS-1:0] sample_c;
  logic [CHANNELS-1:0] toggle_c;

  // Synchroniser shift, then normalise so 1 always means pressed
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.key_in};
  assign sample_c = sync_q[SYNC_STAGES-1] ^ IDLE;

  // Debounce: count consecutive disagreeing samples, toggle on the last one
  always_comb begin
    cnt_d    = cnt_q;
    toggle_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (sample_c[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        toggle_c[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Strobes line up with the cycle the new level first appears; a new press
  // beats a simultaneous clear so no event is lost
  always_comb begin
    level_d   = level_q ^ toggle_c;
    press_d   = toggle_c & ~level_q;
    release_d = toggle_c & level_q;
    cap_d     = press_d | (cap_q & ~({CHANNELS{bus.clr_wr}} & bus.clr_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{IDLE}};
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      cap_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cap_q     <= cap_d;
    end
  end

  assign bus.level_out     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.edge_capture  = cap_q;
  // Interrupt follows capture/enable combinationally
  assign bus.irq           = |(cap_q & bus.irq_en);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (4 channels, 2 sync stages,
// debounce of 4, active-low keys).
module tb_key_conditioner;

  logic clk;
  logic rst;

  key_conditioner_if #(.CHANNELS(4)) bus ();

  key_conditioner #(
    .CHANNELS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  key;
    logic        clr_wr;
    logic [3:0]  clr_mask;
    logic [3:0]  irq_en;
    int unsigned n;
    logic [3:0]  lvl;
    logic [3:0]  prs;
    logic [3:0]  rel;
    logic [3:0]  cap;
    logic        irq;
  } vec_t;

  vec_t vecs[$];
  int   nvec;
  int   nerr;

  function automatic void add(input logic r, input logic [3:0] k, input logic cw,
                              input logic [3:0] cm, input logic [3:0] en,
                              input int unsigned n, input logic [3:0] lvl,
                              input logic [3:0] prs, input logic [3:0] rel,
                              input logic [3:0] cap, input logic irq);
    vec_t v;
    v.rst = r; v.key = k; v.clr_wr = cw; v.clr_mask = cm; v.irq_en = en;
    v.n = n; v.lvl = lvl; v.prs = prs; v.rel = rel; v.cap = cap; v.irq = irq;
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic [3:0] k, input logic cw,
                       input logic [3:0] cm, input logic [3:0] en);
    rst          = r;
    bus.key_in   = k;
    bus.clr_wr   = cw;
    bus.clr_mask = cm;
    bus.irq_en   = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] cap, input logic irq);
    nvec++;
    if (bus.level_out !== lvl || bus.press_pulse !== prs || bus.release_pulse !== rel ||
        bus.edge_capture !== cap || bus.irq !== irq) begin
      nerr++;
      $display("FAIL %s: got level=%h press=%h release=%h cap=%h irq=%b, expected level=%h press=%h release=%h cap=%h irq=%b",
               name, bus.level_out, bus.press_pulse, bus.release_pulse, bus.edge_capture,
               bus.irq, lvl, prs, rel, cap, irq);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    apply(1'b1, 4'hF, 1'b0, 4'h0, 4'hF);

    // Reset and idle
    add(1, 4'hF, 0, 4'h0, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 4'h0, 4'hF, 20, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // Clean press/release on ch1, 6-edge latency each way
    add(0, 4'hD, 0, 4'h0, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hD, 0, 4'h0, 4'hF,  1, 4'h2, 4'h2, 4'h0, 4'h2, 1);
    add(0, 4'hD, 0, 4'h0, 4'hF,  4, 4'h2, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  5, 4'h2, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h2, 4'h2, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    // Bounce on ch2: low 3 / high 1, five times, then a real hold
    for (int i = 0; i < 5; i++) begin
      add(0, 4'hB, 0, 4'h0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h2, 1);
      add(0, 4'hF, 0, 4'h0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    end
    add(0, 4'hB, 0, 4'h0, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'hB, 0, 4'h0, 4'hF,  1, 4'h4, 4'h4, 4'h0, 4'h6, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  5, 4'h4, 4'h0, 4'h0, 4'h6, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h4, 4'h6, 1);
    add(0, 4'hF, 1, 4'hF, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    // Clear colliding with a new ch1 press: set wins; later clear alone works
    add(0, 4'hD, 0, 4'h0, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hD, 0, 4'h0, 4'hF,  1, 4'h2, 4'h2, 4'h0, 4'h2, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  5, 4'h2, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'hF, 0, 4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h2, 4'h2, 1);
    add(0, 4'hD, 0, 4'h0, 4'hF,  5, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    add(0, 4'hD, 1, 4'h2, 4'hF,  1, 4'h2, 4'h2, 4'h0, 4'h2, 1);
    add(0, 4'hD, 1, 4'h2, 4'hF,  1, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hD, 0, 4'h0, 4'hF,  2, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 4'h0, 4'hF,  5, 4'h2, 4'h0, 4'h0, 4'h0, 0);
    add(0, 4'hF, 0, 4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h2, 4'h0, 0);
    add(0, 4'hF, 0, 4'h0, 4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0, 0);

    foreach (vecs[v]) begin
      apply(vecs[v].rst, vecs[v].key, vecs[v].clr_wr, vecs[v].clr_mask, vecs[v].irq_en);
      for (int c = 0; c < int'(vecs[v].n); c++) begin
        tick();
        chk($sformatf("vec%0d.cyc%0d", v, c), vecs[v].lvl, vecs[v].prs, vecs[v].rel,
            vecs[v].cap, vecs[v].irq);
      end
    end

    // Masked irq, simultaneous ch0+ch3 press
    apply(1'b0, 4'h6, 1'b0, 4'h0, 4'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("multi_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick();
    chk("multi_press", 4'h9, 4'h9, 4'h0, 4'h9, 1'b1);
    apply(1'b0, 4'h6, 1'b1, 4'h0, 4'h1);
    tick();
    chk("clr_mask0", 4'h9, 4'h0, 4'h0, 4'h9, 1'b1);
    apply(1'b0, 4'h6, 1'b1, 4'h4, 4'h1);
    tick();
    chk("clr_unset", 4'h9, 4'h0, 4'h0, 4'h9, 1'b1);
    apply(1'b0, 4'h6, 1'b1, 4'h1, 4'h1);
    tick();
    chk("clr_ch0", 4'h9, 4'h0, 4'h0, 4'h8, 1'b0);
    apply(1'b0, 4'h6, 1'b0, 4'h0, 4'h8);
    #1;
    chk("irq_comb", 4'h9, 4'h0, 4'h0, 4'h8, 1'b1);

    // Release ch3, keep ch0 held, then reset mid-hold
    apply(1'b0, 4'hE, 1'b0, 4'h0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rel3_wait", 4'h9, 4'h0, 4'h0, 4'h8, 1'b1);
    end
    tick();
    chk("rel3", 4'h1, 4'h0, 4'h8, 4'h8, 1'b1);
    apply(1'b1, 4'hE, 1'b0, 4'h0, 4'hF);
    tick();
    chk("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    apply(1'b0, 4'hE, 1'b0, 4'h0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_rst_wait", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick();
    chk("post_rst_press", 4'h1, 4'h1, 4'h0, 4'h1, 1'b1);
    tick();
    chk("post_rst_hold", 4'h1, 4'h0, 4'h0, 4'h1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
